// File: rtl/psw_cb_sequencer.sv
// psw_cb_sequencer
// Orders access to the PSW carry/borrow bit between decode and writeback.
// A shift-register scoreboard follows every in-flight C/B writer to its
// commit stage; C/B readers are held at decode until that scoreboard is
// empty, then a one-cycle read of the PSW register is captured for EX.
// PIPE_DEPTH must lie in 2..8 and CNT_W must hold PIPE_DEPTH.

module psw_cb_sequencer #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_cb_wr,
  input  logic             issue_cb_rd,
  input  logic             pipe_advance,
  input  logic             flush,
  input  logic             wb_cb_value,
  input  logic             psw_dout,
  output logic             stall,
  output logic             psw_le,
  output logic             psw_re,
  output logic             psw_din,
  output logic             cb_operand,
  output logic             cb_valid,
  output logic [CNT_W-1:0] pending_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } rd_state_t;

  logic [PIPE_DEPTH-1:0] sb_reg;
  logic [PIPE_DEPTH-1:0] sb_next;
  logic [PIPE_DEPTH-1:0] sb_shift;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  rd_state_t             state_reg;
  rd_state_t             state_next;
  logic                  cb_operand_reg;
  logic                  cb_valid_reg;
  logic                  accept;
  logic                  rd_start;

  // A reader waits for every older writer; no forwarding from the commit
  // stage, so a reader is only released the cycle after the last commit.
  assign stall    = issue_valid & issue_cb_rd & (|sb_reg);
  assign accept   = issue_valid & ~stall & pipe_advance;
  assign rd_start = accept & issue_cb_rd & ~flush;

  // Commit strobe comes straight from the last scoreboard stage.
  assign psw_le  = sb_reg[PIPE_DEPTH-1] & pipe_advance;
  assign psw_din = wb_cb_value;

  // Shifted scoreboard image; flush squashes everything that would land in
  // the stages below commit, including a writer issued in the same cycle.
  assign sb_shift[0] = accept & issue_cb_wr & ~flush;
  generate
    for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_shift
      assign sb_shift[gi] = sb_reg[gi-1] & ~flush;
    end
  endgenerate

  // Next scoreboard: shift on advance, otherwise hold (flush still clears
  // the non-commit stages while the committing writer waits).
  always_comb begin
    sb_next = sb_reg;
    if (pipe_advance) begin
      sb_next = sb_shift;
    end else if (flush) begin
      sb_next = {sb_reg[PIPE_DEPTH-1], {(PIPE_DEPTH-1){1'b0}}};
    end
  end

  // Population count of the next scoreboard, registered with it.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      cnt_next = cnt_next + CNT_W'(sb_next[i]);
    end
  end

  // Scoreboard and writer count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      sb_reg  <= sb_next;
      cnt_reg <= cnt_next;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state and read strobe; RD lasts one cycle per reader.
  always_comb begin
    state_next = ST_IDLE;
    psw_re     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rd_start) begin
          state_next = ST_RD;
        end
      end
      ST_RD: begin
        psw_re = 1'b1;
        if (rd_start) begin
          state_next = ST_RD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the PSW output at the end of each RD cycle; flush does not
  // cancel a capture already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_operand_reg <= 1'b0;
      cb_valid_reg   <= 1'b0;
    end else if (state_reg == ST_RD) begin
      cb_operand_reg <= psw_dout;
      cb_valid_reg   <= 1'b1;
    end else begin
      cb_valid_reg   <= 1'b0;
    end
  end

  assign cb_operand  = cb_operand_reg;
  assign cb_valid    = cb_valid_reg;
  assign pending_cnt = cnt_reg;

endmodule

// File: tb/tb_psw_cb_sequencer.sv
// tb_psw_cb_sequencer
// Directed scenarios for psw_cb_sequencer (PIPE_DEPTH=3). A one-bit PSW
// register model sits behind the LE/RE strobes. Inputs change 1 ns after
// the rising edge; outputs are checked on the falling edge.

module tb_psw_cb_sequencer;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic       issue_cb_wr;
  logic       issue_cb_rd;
  logic       pipe_advance;
  logic       flush;
  logic       wb_cb_value;
  logic       psw_dout;
  logic       stall;
  logic       psw_le;
  logic       psw_re;
  logic       psw_din;
  logic       cb_operand;
  logic       cb_valid;
  logic [1:0] pending_cnt;

  logic       psw_val;
  int         n_tests;
  int         n_fail;

  psw_cb_sequencer #(
    .PIPE_DEPTH(3),
    .CNT_W     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_cb_wr (issue_cb_wr),
    .issue_cb_rd (issue_cb_rd),
    .pipe_advance(pipe_advance),
    .flush       (flush),
    .wb_cb_value (wb_cb_value),
    .psw_dout    (psw_dout),
    .stall       (stall),
    .psw_le      (psw_le),
    .psw_re      (psw_re),
    .psw_din     (psw_din),
    .cb_operand  (cb_operand),
    .cb_valid    (cb_valid),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External one-bit PSW C/B register; reads back 0 when not enabled.
  initial psw_val = 1'b0;
  always @(posedge clk) begin
    if (psw_le) psw_val <= psw_din;
  end
  assign psw_dout = psw_re ? psw_val : 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] pass %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    issue_valid  = 1'b0;
    issue_cb_wr  = 1'b0;
    issue_cb_rd  = 1'b0;
    pipe_advance = 1'b1;
    flush        = 1'b0;
    wb_cb_value  = 1'b0;

    // Reset state
    smp();
    check_eq("rst_stall", 8'(stall), 8'd0);
    check_eq("rst_le", 8'(psw_le), 8'd0);
    check_eq("rst_re", 8'(psw_re), 8'd0);
    check_eq("rst_cnt", 8'(pending_cnt), 8'd0);
    check_eq("rst_cbv", 8'(cb_valid), 8'd0);
    check_eq("rst_cbop", 8'(cb_operand), 8'd0);
    tick();
    rst_n = 1'b1;

    // Idle with pipe advancing
    for (int i = 0; i < 3; i++) begin
      smp();
      check_eq($sformatf("idle%0d_stall", i), 8'(stall), 8'd0);
      check_eq($sformatf("idle%0d_le", i), 8'(psw_le), 8'd0);
      check_eq($sformatf("idle%0d_re", i), 8'(psw_re), 8'd0);
      check_eq($sformatf("idle%0d_cnt", i), 8'(pending_cnt), 8'd0);
      tick();
    end

    // Writer (value 1) then dependent reader
    wb_cb_value = 1'b1;
    issue_valid = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    check_eq("wr_rd_c0_stall", 8'(stall), 8'd0);
    tick();
    issue_cb_wr = 1'b0;
    issue_cb_rd = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      smp();
      check_eq($sformatf("wr_rd_c%0d_stall", c), 8'(stall), (c <= 3) ? 8'd1 : 8'd0);
      check_eq($sformatf("wr_rd_c%0d_le", c), 8'(psw_le), (c == 3) ? 8'd1 : 8'd0);
      tick();
    end
    issue_valid = 1'b0;
    issue_cb_rd = 1'b0;
    smp();
    check_eq("wr_rd_c5_re", 8'(psw_re), 8'd1);
    check_eq("wr_rd_c5_cbv", 8'(cb_valid), 8'd0);
    tick();
    smp();
    check_eq("wr_rd_c6_cbv", 8'(cb_valid), 8'd1);
    check_eq("wr_rd_c6_cbop", 8'(cb_operand), 8'd1);
    check_eq("wr_rd_c6_re", 8'(psw_re), 8'd0);
    tick();
    smp();
    check_eq("wr_rd_c7_cbv", 8'(cb_valid), 8'd0);
    tick();

    // Single writer commit latency
    issue_valid = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    tick();
    issue_valid = 1'b0;
    issue_cb_wr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      smp();
      check_eq($sformatf("wr1_c%0d_le", k), 8'(psw_le), (k == 3) ? 8'd1 : 8'd0);
      check_eq($sformatf("wr1_c%0d_cnt", k), 8'(pending_cnt), (k <= 3) ? 8'd1 : 8'd0);
      if (k == 3) check_eq("wr1_c3_din", 8'(psw_din), 8'd1);
      tick();
    end

    // Writer held by pipe_advance=0 with a stalled reader
    issue_valid = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    tick();
    issue_cb_wr  = 1'b0;
    issue_cb_rd  = 1'b1;
    pipe_advance = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      smp();
      check_eq($sformatf("hold_c%0d_stall", c), 8'(stall), 8'd1);
      check_eq($sformatf("hold_c%0d_le", c), 8'(psw_le), 8'd0);
      check_eq($sformatf("hold_c%0d_cnt", c), 8'(pending_cnt), 8'd1);
      tick();
    end
    pipe_advance = 1'b1;
    issue_valid  = 1'b0;
    issue_cb_rd  = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      smp();
      check_eq($sformatf("hold_c%0d_le", c), 8'(psw_le), (c == 7) ? 8'd1 : 8'd0);
      tick();
    end
    smp();
    check_eq("hold_c8_cnt", 8'(pending_cnt), 8'd0);
    tick();

    // Two writers then flush; a writer issued with the flush is dropped
    wb_cb_value = 1'b0;
    issue_valid = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    tick();
    smp();
    tick();
    issue_valid = 1'b0;
    issue_cb_wr = 1'b0;
    smp();
    check_eq("fl_c2_cnt", 8'(pending_cnt), 8'd2);
    tick();
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    check_eq("fl_c3_le", 8'(psw_le), 8'd1);
    check_eq("fl_c3_din", 8'(psw_din), 8'd0);
    check_eq("fl_c3_cnt", 8'(pending_cnt), 8'd2);
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_cb_wr = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      smp();
      check_eq($sformatf("fl_c%0d_le", c), 8'(psw_le), 8'd0);
      check_eq($sformatf("fl_c%0d_cnt", c), 8'(pending_cnt), 8'd0);
      tick();
    end

    // Read-modify-write instruction reads the old C/B (0), commits 1 later
    wb_cb_value = 1'b1;
    issue_valid = 1'b1;
    issue_cb_rd = 1'b1;
    issue_cb_wr = 1'b1;
    smp();
    check_eq("rmw_c0_stall", 8'(stall), 8'd0);
    tick();
    issue_valid = 1'b0;
    issue_cb_rd = 1'b0;
    issue_cb_wr = 1'b0;
    smp();
    check_eq("rmw_c1_re", 8'(psw_re), 8'd1);
    check_eq("rmw_c1_cnt", 8'(pending_cnt), 8'd1);
    tick();
    smp();
    check_eq("rmw_c2_cbv", 8'(cb_valid), 8'd1);
    check_eq("rmw_c2_cbop", 8'(cb_operand), 8'd0);
    tick();
    smp();
    check_eq("rmw_c3_le", 8'(psw_le), 8'd1);
    tick();

    // Back-to-back readers, reset during the second read
    issue_valid = 1'b1;
    issue_cb_rd = 1'b1;
    smp();
    check_eq("b2b_c0_stall", 8'(stall), 8'd0);
    check_eq("b2b_c0_re", 8'(psw_re), 8'd0);
    tick();
    smp();
    check_eq("b2b_c1_stall", 8'(stall), 8'd0);
    check_eq("b2b_c1_re", 8'(psw_re), 8'd1);
    tick();
    issue_valid = 1'b0;
    issue_cb_rd = 1'b0;
    smp();
    check_eq("b2b_c2_re", 8'(psw_re), 8'd1);
    check_eq("b2b_c2_cbv", 8'(cb_valid), 8'd1);
    check_eq("b2b_c2_cbop", 8'(cb_operand), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("b2b_rst_cbv", 8'(cb_valid), 8'd0);
    check_eq("b2b_rst_re", 8'(psw_re), 8'd0);
    check_eq("b2b_rst_cnt", 8'(pending_cnt), 8'd0);
    tick();
    rst_n = 1'b1;
    smp();
    check_eq("b2b_post_re", 8'(psw_re), 8'd0);
    check_eq("b2b_post_cbv", 8'(cb_valid), 8'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
